// File: rtl/cordic_act_unit.sv
// Streaming activation unit: sigmoid, tanh and exp on one iterative hyperbolic CORDIC
// with a linear-mode divide pass, plus ReLU and range-saturation bypass.
module cordic_act_unit #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 14,
   parameter int ITER  = 16,
   parameter int KINV  = 19784,
   parameter int XMAX  = 18317
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic [1:0]              func_select,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH:0]   result,
   output logic [1:0]              out_func,
   output logic                    sat
);
   localparam int DW    = WIDTH + 2;
   localparam int RW    = WIDTH + 1;
   localparam int TSH_L = (FRAC >= 14) ? FRAC - 14 : 0;
   localparam int TSH_R = (FRAC < 14) ? 14 - FRAC : 0;
   localparam logic signed [DW-1:0] ONE     = DW'(1) <<< FRAC;
   localparam logic signed [DW-1:0] XMAX_P  = DW'(XMAX);
   localparam logic signed [DW-1:0] XMAX_N  = -XMAX_P;
   localparam logic signed [DW-1:0] XMAX2_P = DW'(2 * XMAX);
   localparam logic signed [DW-1:0] XMAX2_N = -XMAX2_P;
   localparam logic signed [DW-1:0] KINV_D  = DW'(KINV);
   localparam logic signed [DW-1:0] EXP_MAX = {2'b00, {WIDTH{1'b1}}};
   localparam logic [4:0]           ITER_I   = 5'(ITER);
   localparam logic [4:0]           DIV_LAST = 5'(ITER - 1);

   typedef enum logic [2:0] {IDLE, HYP, DIV, POST, OUT} state_t;

   // Table is held at 14 fractional bits and rescaled to FRAC
   function automatic logic signed [DW-1:0] atanh_tab(input logic [4:0] i);
      int v;
      case (i)
         5'd1:    v = 9000;
         5'd2:    v = 4185;
         5'd3:    v = 2059;
         5'd4:    v = 1025;
         5'd5:    v = 512;
         5'd6:    v = 256;
         5'd7:    v = 128;
         5'd8:    v = 64;
         5'd9:    v = 32;
         5'd10:   v = 16;
         5'd11:   v = 8;
         5'd12:   v = 4;
         5'd13:   v = 2;
         5'd14:   v = 1;
         5'd15:   v = 1;
         default: v = 0;
      endcase
      return (DW'(v) <<< TSH_L) >>> TSH_R;
   endfunction

   state_t               state;
   logic [4:0]           idx;
   logic                 rep;
   logic [1:0]           func_q;
   logic                 byp_q;
   logic signed [DW-1:0] x_r, y_r, z_r, q_r;
   logic signed [DW-1:0] x_sh, y_sh, one_sh, tab;
   logic signed [DW-1:0] hyp_x, hyp_y, hyp_z, div_y, div_q;
   logic signed [DW-1:0] x_ext, a_init, byp_val;
   logic                 d_pos, rep_idx, hyp_last, byp_hit;

   // One CORDIC step for either mode; the FSM picks which results to keep
   always_comb begin
      x_sh     = x_r >>> idx;
      y_sh     = y_r >>> idx;
      one_sh   = ONE >>> idx;
      tab      = atanh_tab(idx);
      d_pos    = ~z_r[DW-1];
      hyp_x    = d_pos ? x_r + y_sh : x_r - y_sh;
      hyp_y    = d_pos ? y_r + x_sh : y_r - x_sh;
      hyp_z    = d_pos ? z_r - tab : z_r + tab;
      div_y    = y_r[DW-1] ? y_r + x_sh : y_r - x_sh;
      div_q    = y_r[DW-1] ? q_r - one_sh : q_r + one_sh;
      rep_idx  = (idx == 5'd4) || (idx == 5'd13);
      hyp_last = (idx == ITER_I) && !(rep_idx && !rep);
   end

   // Out-of-range arguments never reach the core, which would not converge on them
   always_comb begin
      x_ext   = {{2{x_in[WIDTH-1]}}, x_in};
      a_init  = (func_select == 2'b00) ? (x_ext >>> 1) : x_ext;
      byp_hit = 1'b0;
      byp_val = '0;
      case (func_select)
         2'b11: begin
            byp_hit = 1'b1;
            byp_val = x_ext[DW-1] ? '0 : x_ext;
         end
         2'b01: begin
            if (x_ext > XMAX_P) begin
               byp_hit = 1'b1;
               byp_val = ONE;
            end else if (x_ext < XMAX_N) begin
               byp_hit = 1'b1;
               byp_val = -ONE;
            end
         end
         2'b00: begin
            if (x_ext > XMAX2_P) begin
               byp_hit = 1'b1;
               byp_val = ONE;
            end else if (x_ext < XMAX2_N) begin
               byp_hit = 1'b1;
            end
         end
         default: begin
            if (x_ext > XMAX_P) begin
               byp_hit = 1'b1;
               byp_val = EXP_MAX;
            end else if (x_ext < XMAX_N) begin
               byp_hit = 1'b1;
            end
         end
      endcase
   end

   // Control FSM and datapath registers; a bypass value is parked in y_r until POST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         out_func  <= '0;
         sat       <= 1'b0;
         func_q    <= '0;
         byp_q     <= 1'b0;
         idx       <= '0;
         rep       <= 1'b0;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         q_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  func_q   <= func_select;
                  byp_q    <= byp_hit;
                  if (byp_hit) begin
                     y_r   <= byp_val;
                     state <= POST;
                  end else begin
                     x_r   <= KINV_D;
                     y_r   <= '0;
                     z_r   <= a_init;
                     q_r   <= '0;
                     idx   <= 5'd1;
                     rep   <= 1'b0;
                     state <= HYP;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            HYP: begin
               x_r <= hyp_x;
               y_r <= hyp_y;
               z_r <= hyp_z;
               if (hyp_last) begin
                  idx   <= '0;
                  rep   <= 1'b0;
                  state <= (func_q == 2'b10) ? POST : DIV;
               end else if (rep_idx && !rep) begin
                  rep <= 1'b1;
               end else begin
                  idx <= idx + 5'd1;
                  rep <= 1'b0;
               end
            end
            DIV: begin
               y_r <= div_y;
               q_r <= div_q;
               if (idx == DIV_LAST) state <= POST;
               else idx <= idx + 5'd1;
            end
            POST: begin
               out_valid <= 1'b1;
               out_func  <= func_q;
               sat       <= byp_q;
               state     <= OUT;
               if (byp_q) begin
                  result <= y_r[RW-1:0];
               end else begin
                  case (func_q)
                     2'b00:   result <= RW'((ONE + q_r) >>> 1);
                     2'b01:   result <= RW'(q_r);
                     2'b10:   result <= RW'(x_r + y_r);
                     default: result <= '0;
                  endcase
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/cordic_act_unit.md
Name: cordic_act_unit

Overview:
Multi-function activation engine built on one iterative hyperbolic CORDIC core, with an optional linear-mode division pass. It computes sigmoid, tanh, exp and ReLU on signed fixed-point inputs in Q(WIDTH-FRAC).FRAC format. It replaces the single start/busy/done CORDIC interface with valid/ready streaming handshakes and adds input-range saturation. It sits between the MAC array output and the activation write-back buffer.

Parameters:
WIDTH, 32, input data width (signed); result is WIDTH+1 bits.
FRAC, 14, fractional bits of input and result.
ITER, 16, hyperbolic/linear iteration count, legal range 8..24.
KINV, 19784, 1/K_h with repeats at indices 4 and 13, as round(1.20750*2^FRAC).
XMAX, 18317, convergence limit round(1.118*2^FRAC) on the hyperbolic-core argument.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input word valid.
in_ready  out  1  unit can accept input.
x_in  in  WIDTH  signed Q.FRAC operand.
func_select  in  2  function code: 00 sigmoid, 01 tanh, 10 exp, 11 ReLU.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
result  out  WIDTH+1  signed Q.FRAC result.
out_func  out  2  func_select captured with this result.
sat  out  1  result was produced by the saturation or bypass path, not by CORDIC.

Behaviour:
- Reset (async, any state): state=IDLE. in_ready=0 while rst_n low, 1 on the first cycle after release. out_valid=0, result=0, out_func=0, sat=0. An operation in flight is discarded, and no output is produced for it.
- Accept: an input is accepted on a rising edge with in_valid&&in_ready. in_ready=1 only in IDLE. x_in and func_select are registered at accept and ignored afterwards.
- States and transitions:
  - IDLE -> HYP on accept.
  - IDLE -> POST on accept when the bypass condition holds (see Bypass and saturation).
  - HYP -> DIV (tanh/sigmoid) or POST (exp) after N_HYP cycles.
  - DIV -> POST after ITER cycles.
  - POST -> OUT after 1 cycle.
  - OUT -> IDLE on out_valid&&out_ready.
- HYP:
  - Hyperbolic rotation mode. Init x=KINV, y=0, z=a.
  - a = x_in for tanh and exp; a = x_in>>>1 (arithmetic) for sigmoid.
  - Shift indices i=1..ITER, with i=4 and i=13 each executed twice when they are ≤ITER. N_HYP = ITER + count of those repeats (18 at default).
  - d = sign(z), with z≥0 giving +1. x+=d*(y>>>i); y+=d*(x>>>i); z-=d*atanh_tab[i].
  - atanh_tab[i] = round(atanh(2^-i)*2^FRAC).
  - Internal datapath WIDTH+2 bits.
- DIV:
  - Linear vectoring mode computing y/x. Init q=0; the cosh term is the divisor.
  - Indices i=0..ITER-1: if y≥0 then y-=x>>>i, q+=ONE>>>i; else y+=x>>>i, q-=ONE>>>i. ONE = 2^FRAC.
- POST produces the result:
  - tanh: q.
  - sigmoid: (ONE+q)>>>1.
  - exp: x+y.
- Latency from accept edge to out_valid high:
  - exp: N_HYP+2 (20 at default).
  - tanh and sigmoid: N_HYP+ITER+2 (36 at default).
  - bypass: 2.
- Bypass and saturation (decided at accept; skips HYP/DIV; sets sat=1):
  - ReLU: result = max(x_in,0), sign-extended.
  - tanh with |x_in|>XMAX: ±ONE.
  - sigmoid with |x_in|>2*XMAX: ONE if positive, 0 if negative.
  - exp with x_in>XMAX: max positive value 2^WIDTH-1.
  - exp with x_in<-XMAX: 0.
  - CORDIC results have sat=0.
- Output hold: while out_valid=1 and out_ready=0, result, out_func and sat are held stable. out_ready is ignored when out_valid=0.
- Throughput: one operation in flight. After an output handshake, the earliest next accept is the following edge.
- Accuracy for non-saturated inputs: |error| ≤ 0.01 absolute, i.e. 164 LSB at FRAC=14.

Test Plan:
- Reset release; sigmoid, x_in=0 -> after 36 cycles result=8192±164, sat=0, out_func=00.
- tanh, x_in=8192 (0.5) -> result ≈7571±164 (0.462117). exp, x_in=16384 (1.0) -> result ≈44536±164 (2.718282), latency exactly 20.
- ReLU, x_in=-16384 -> result=0, sat=1, latency 2. ReLU, x_in=12288 -> result=12288.
- tanh, x_in=32768 (2.0) -> result=16384, sat=1. Sigmoid, x_in=-65536 -> result=0, sat=1. Exp, x_in=-32768 -> result=0, sat=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0. Then release out_ready -> in_ready=1 on the next cycle. Sweep x=±0.25, ±0.5, ±0.75, ±1.0 for all functions, each within 164 LSB.
- Assert rst_n=0 mid-HYP -> out_valid=0 and result=0 immediately. After release, no stale output appears, and a fresh tanh(0)=0±164 completes correctly.
